bit_stream_window_feeder_32x16: RTL and testbench
=================================================

Name: bit_stream_window_feeder_32x16

Overview:
- Upstream stage of the 32-to-16 bit selection network.
- Accepts an LSB-first bit stream as 16-bit words over a valid/ready handshake and keeps a 32-bit sliding window {hi word, lo word}.
- Drives the window as o_data_bus and the 4-bit shift command o_cmd. The combinational selector then returns the next 16 unconsumed bits, which are window[o_cmd+16 : o_cmd+1].
- Downstream states how many bits it consumed per transfer (0..16). The feeder advances its pointer and retires words.

Parameters:
- DATA_WIDTH, 32, window width; only 32 supported.
- IN_WIDTH, DATA_WIDTH>>1 = 16, input word width.
- COMMAND_WIDTH, $clog2(DATA_WIDTH)-1 = 4, o_cmd width.
- LEN_WIDTH, $clog2(IN_WIDTH)+1 = 5, consume-length width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- i_en  in  1  stage enable; 0 freezes all state.
- i_flush  in  1  discard window contents and return to reset state.
- i_valid  in  1  input word valid.
- i_data  in  16  input word; bit 0 is the earliest bit in the stream.
- o_ready  out  1  input word accepted when i_valid && o_ready.
- o_valid  out  1  window holds 16 unconsumed bits starting at the pointer.
- o_data_bus  out  32  {win_hi, win_lo}.
- o_cmd  out  4  ptr-1; drives the selector's i_cmd.
- i_ready  in  1  downstream accepts the window.
- i_consume_len  in  5  bits consumed on fire; values >16 are clamped to 16.

Behaviour:
- One clock domain, synchronous active-low reset. This is the only reset.
- State: win_lo[15:0], win_hi[15:0], lo_vld, hi_vld, ptr[4:0] (range 1..16). ptr is the index in the window of the first unconsumed bit.
- Reset / flush: ptr=16, lo_vld=0, hi_vld=0, win_lo=win_hi=0.
- Outputs after reset: o_valid=0, o_ready=1, o_cmd=15, o_data_bus=0.
- i_flush takes priority over in/out transfers in the same cycle.
- i_en=0: o_valid=0, o_ready=0, state held. i_flush and rst_n still act.
- All outputs are decoded combinationally from registered state. There is no combinational path from i_ready or i_consume_len to o_valid or o_data_bus.
- o_valid = i_en && hi_vld && (ptr==16 || lo_vld).
- fire = o_valid && i_ready. p_new = ptr + min(len,16), 6-bit arithmetic, range 1..32.
- drop = fire && (p_new > 16).
  - drop: win_lo<=win_hi, lo_vld<=1, hi_vld<=0, ptr<=p_new-16.
  - fire && !drop: ptr<=p_new; words unchanged.
  - len=0 fire is a peek; no state change.
- o_ready = i_en && !i_flush && (!hi_vld || drop).
- accept = i_valid && o_ready: win_hi<=i_data, hi_vld<=1. This overrides the hi_vld clear from drop in the same cycle.
- Simultaneous drop+accept sustains 16 bits/cycle, e.g. ptr=16 with len=16 every cycle.
- Cold start: ptr=16 selects win_hi alone, so the first word is usable before win_lo is valid.
- p_new=32 (ptr=16, len=16): ptr returns to 16. o_valid then needs a new hi word.
- win_lo is never emitted as target bits while lo_vld=0 (guaranteed by the ptr==16 rule).
- Latency: word accepted in cycle N is visible on o_valid in cycle N+1.

Decomposition:
- Shared package holds:
  - constants: DATA_WIDTH, IN_WIDTH, COMMAND_WIDTH, LEN_WIDTH, PTR_RESET=16.
  - helper: the cmd = ptr-1 mapping.
- No sub-module. The selector is instantiated by the parent, not inside this block.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> o_valid=0, o_ready=1, o_cmd=15, o_data_bus=0.
- Cold start: push 16'h0810 -> next cycle o_valid=1, o_cmd=15, o_data_bus[31:16]=16'h0810, selector output 16'h0810.
- Unaligned consume:
  - Consume len=1 -> o_valid=0, ptr=1.
  - Push 16'hA442 -> o_data_bus=32'hA4420810, o_cmd=0, selector 16'h0408.
  - Consume len=1 -> o_cmd=1, selector 16'h8204.
  - Consume len=14 -> o_cmd=15, selector 16'hA442.
- Streaming: words 1..8 pushed back-to-back, i_ready=1, len=16 -> one fire per cycle after the first, selector output equals each word in order, o_ready never drops.
- Backpressure / peek:
  - i_ready=0 with hi_vld=1 -> o_ready=0, window held.
  - len=0 fire -> ptr unchanged.
  - len=20 -> behaves as len=16.
- Flush/enable:
  - i_flush mid-stream (ptr=5) -> next cycle ptr=16, o_valid=0, even with i_valid asserted in that cycle.
  - i_en=0 -> o_valid=o_ready=0, state preserved; resumes identically when i_en returns to 1.

Source files
------------

// File: rtl/bit_stream_window_feeder_32x16_pkg.sv
// Shared constants and helpers for the 32-bit sliding-window bit stream feeder.
package bit_stream_window_feeder_32x16_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int IN_WIDTH      = DATA_WIDTH >> 1;
    localparam int COMMAND_WIDTH = $clog2(DATA_WIDTH) - 1;
    localparam int LEN_WIDTH     = $clog2(IN_WIDTH) + 1;
    localparam int PTR_WIDTH     = LEN_WIDTH;

    localparam logic [PTR_WIDTH-1:0] PTR_RESET = 5'd16;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX   = 5'd16;

    // Selector shift command: the selector returns window[cmd+16:cmd+1],
    // so the first unconsumed bit at index ptr maps to cmd = ptr - 1.
    function automatic logic [COMMAND_WIDTH-1:0] ptr_to_cmd(input logic [PTR_WIDTH-1:0] ptr);
        return COMMAND_WIDTH'(ptr - 5'd1);
    endfunction

endpackage

// File: rtl/bit_stream_window_feeder_32x16.sv
// Feeds a 32-bit sliding window {hi, lo} of an LSB-first bit stream to the
// downstream 32-to-16 selector and retires words as bits are consumed.
module bit_stream_window_feeder_32x16
    import bit_stream_window_feeder_32x16_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  logic [IN_WIDTH-1:0]      i_data,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_data_bus,
    output logic [COMMAND_WIDTH-1:0] o_cmd,
    input  logic                     i_ready,
    input  logic [LEN_WIDTH-1:0]     i_consume_len
);

    logic [IN_WIDTH-1:0]  win_lo_r;
    logic [IN_WIDTH-1:0]  win_hi_r;
    logic                 lo_vld_r;
    logic                 hi_vld_r;
    logic [PTR_WIDTH-1:0] ptr_r;

    logic [IN_WIDTH-1:0]  win_lo_nxt_s;
    logic [IN_WIDTH-1:0]  win_hi_nxt_s;
    logic                 lo_vld_nxt_s;
    logic                 hi_vld_nxt_s;
    logic [PTR_WIDTH-1:0] ptr_nxt_s;

    logic [LEN_WIDTH-1:0] len_clamp_s;
    logic [5:0]           p_new_s;
    logic                 valid_s;
    logic                 ready_s;
    logic                 fire_s;
    logic                 drop_s;
    logic                 accept_s;

    // Handshake decode: valid/ready come from registered state; o_ready may
    // rise on a same-cycle drop so a full window can stream 16 bits per cycle.
    always_comb begin
        len_clamp_s = i_consume_len;
        if (i_consume_len > LEN_MAX) begin
            len_clamp_s = LEN_MAX;
        end else begin
            len_clamp_s = i_consume_len;
        end
        p_new_s  = {1'b0, ptr_r} + {1'b0, len_clamp_s};
        valid_s  = i_en && hi_vld_r && ((ptr_r == PTR_RESET) || lo_vld_r);
        fire_s   = valid_s && i_ready;
        drop_s   = fire_s && (p_new_s > 6'd16);
        ready_s  = i_en && !i_flush && (!hi_vld_r || drop_s);
        accept_s = i_valid && ready_s;
    end

    // Next-state: flush wins, then pointer advance / word retire, then refill of hi.
    always_comb begin
        win_lo_nxt_s = win_lo_r;
        win_hi_nxt_s = win_hi_r;
        lo_vld_nxt_s = lo_vld_r;
        hi_vld_nxt_s = hi_vld_r;
        ptr_nxt_s    = ptr_r;
        if (i_flush) begin
            win_lo_nxt_s = '0;
            win_hi_nxt_s = '0;
            lo_vld_nxt_s = 1'b0;
            hi_vld_nxt_s = 1'b0;
            ptr_nxt_s    = PTR_RESET;
        end else if (i_en) begin
            if (drop_s) begin
                win_lo_nxt_s = win_hi_r;
                lo_vld_nxt_s = 1'b1;
                hi_vld_nxt_s = 1'b0;
                ptr_nxt_s    = PTR_WIDTH'(p_new_s - 6'd16);
            end else if (fire_s) begin
                ptr_nxt_s    = p_new_s[PTR_WIDTH-1:0];
            end else begin
                ptr_nxt_s    = ptr_r;
            end
            if (accept_s) begin
                win_hi_nxt_s = i_data;
                hi_vld_nxt_s = 1'b1;
            end else begin
                win_hi_nxt_s = win_hi_r;
            end
        end else begin
            ptr_nxt_s    = ptr_r;
        end
    end

    // Window state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_lo_r <= '0;
            win_hi_r <= '0;
            lo_vld_r <= 1'b0;
            hi_vld_r <= 1'b0;
            ptr_r    <= PTR_RESET;
        end else begin
            win_lo_r <= win_lo_nxt_s;
            win_hi_r <= win_hi_nxt_s;
            lo_vld_r <= lo_vld_nxt_s;
            hi_vld_r <= hi_vld_nxt_s;
            ptr_r    <= ptr_nxt_s;
        end
    end

    assign o_valid    = valid_s;
    assign o_ready    = ready_s;
    assign o_data_bus = {win_hi_r, win_lo_r};
    assign o_cmd      = ptr_to_cmd(ptr_r);

endmodule

// File: tb/tb_bit_stream_window_feeder_32x16.sv
// Self-checking bench: directed plan followed by random traffic, checked
// against a bit-queue model of the unconsumed stream.
module tb_bit_stream_window_feeder_32x16;

    logic        clk;
    logic        rst_n;
    logic        i_en;
    logic        i_flush;
    logic        i_valid;
    logic [15:0] i_data;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_data_bus;
    logic [3:0]  o_cmd;
    logic        i_ready;
    logic [4:0]  i_consume_len;

    int tests_run;
    int tests_failed;

    // Unconsumed stream bits, oldest first.
    bit stream_q[$];

    bit_stream_window_feeder_32x16 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_en          (i_en),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_ready       (o_ready),
        .o_valid       (o_valid),
        .o_data_bus    (o_data_bus),
        .o_cmd         (o_cmd),
        .i_ready       (i_ready),
        .i_consume_len (i_consume_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the external selector would return for this window and command.
    function automatic logic [15:0] sel_of(input logic [31:0] bus, input logic [3:0] cmd);
        logic [31:0] t;
        t = bus >> ({1'b0, cmd} + 5'd1);
        return t[15:0];
    endfunction

    // Next 16 stream bits as a word (bit 0 = earliest).
    function automatic logic [15:0] model_next16();
        logic [15:0] w;
        w = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (i < stream_q.size()) w[i] = stream_q[i];
            else                     w[i] = 1'b0;
        end
        return w;
    endfunction

    // Index of the first unconsumed bit implied by how many bits are resident:
    // with a full hi word the unconsumed bits end at window bit 31, else at 15.
    function automatic logic [3:0] model_cmd();
        int avail;
        int ptr;
        avail = stream_q.size();
        if (avail >= 16) ptr = 32 - avail;
        else             ptr = 16 - avail;
        return 4'(ptr - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check combinational outputs, update model.
    task automatic step(input logic en, input logic flush, input logic vld,
                        input logic [15:0] data, input logic rdy, input logic [4:0] len);
        int  avail;
        int  lenc;
        bit  exp_valid;
        bit  exp_fire;
        bit  exp_ready;
        i_en = en; i_flush = flush; i_valid = vld; i_data = data;
        i_ready = rdy; i_consume_len = len;
        #1;
        avail     = stream_q.size();
        lenc      = (int'(len) > 16) ? 16 : int'(len);
        exp_valid = en && (avail >= 16);
        exp_fire  = exp_valid && rdy;
        exp_ready = en && !flush && ((avail < 16) || (exp_fire && (avail - lenc < 16)));
        chk("o_valid", {31'd0, o_valid}, {31'd0, exp_valid});
        chk("o_ready", {31'd0, o_ready}, {31'd0, exp_ready});
        chk("o_cmd", {28'd0, o_cmd}, {28'd0, model_cmd()});
        if (exp_valid) chk("selector", {16'd0, sel_of(o_data_bus, o_cmd)}, {16'd0, model_next16()});
        if (flush) begin
            stream_q.delete();
        end else begin
            if (exp_fire) for (int i = 0; i < lenc; i++) void'(stream_q.pop_front());
            if (vld && exp_ready) for (int i = 0; i < 16; i++) stream_q.push_back(data[i]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0; i_en = 1'b1; i_flush = 1'b0; i_valid = 1'b0;
        i_data = 16'h0000; i_ready = 1'b0; i_consume_len = 5'd0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_cmd", {28'd0, o_cmd}, 32'd15);
        chk("rst_bus", o_data_bus, 32'h0000_0000);
        @(posedge clk); #1;

        // Cold start and unaligned consumption.
        step(1'b1, 1'b0, 1'b1, 16'h0810, 1'b0, 5'd0);
        chk("cold_hi", {16'd0, o_data_bus[31:16]}, 32'h0000_0810);
        chk("cold_sel", {16'd0, sel_of(o_data_bus, o_cmd)}, 32'h0000_0810);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 5'd1);
        chk("len1_valid", {31'd0, o_valid}, 32'd0);
        chk("len1_cmd", {28'd0, o_cmd}, 32'd0);
        step(1'b1, 1'b0, 1'b1, 16'hA442, 1'b0, 5'd0);
        chk("push2_bus", o_data_bus, 32'hA442_0810);
        chk("push2_sel", {16'd0, sel_of(o_data_bus, o_cmd)}, 32'h0000_0408);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 5'd1);
        chk("c1_cmd", {28'd0, o_cmd}, 32'd1);
        chk("c1_sel", {16'd0, sel_of(o_data_bus, o_cmd)}, 32'h0000_8204);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 5'd14);
        chk("c14_cmd", {28'd0, o_cmd}, 32'd15);
        chk("c14_sel", {16'd0, sel_of(o_data_bus, o_cmd)}, 32'h0000_A442);

        // Backpressure, peek, oversize length.
        step(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0, 5'd0);
        chk("bp_bus", o_data_bus, 32'hA442_0810);
        step(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1, 5'd0);
        chk("peek_cmd", {28'd0, o_cmd}, 32'd15);
        step(1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 5'd20);
        chk("len20_bus", o_data_bus, 32'h1234_A442);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 5'd5);
        chk("p5_cmd", {28'd0, o_cmd}, 32'd4);

        // Flush with a word offered in the same cycle.
        step(1'b1, 1'b1, 1'b1, 16'h5555, 1'b1, 5'd3);
        chk("flush_valid", {31'd0, o_valid}, 32'd0);
        chk("flush_cmd", {28'd0, o_cmd}, 32'd15);
        chk("flush_bus", o_data_bus, 32'h0000_0000);

        // Enable low freezes everything.
        step(1'b1, 1'b0, 1'b1, 16'hC3A5, 1'b0, 5'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 16'h7777, 1'b1, 5'd7);
        chk("en_hold_bus", o_data_bus, 32'hC3A5_0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 5'd16);

        // Back-to-back streaming at 16 bits per cycle.
        for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 1'b1, 16'(k), 1'b1, 5'd16);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 5'd16);
        chk("stream_drained", {31'd0, o_valid}, 32'd0);

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) != 0), 16'($urandom()),
                 ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
